// File: rtl/sim_halt_pkg.sv
// sim_halt_pkg: shared status and state encodings for the halt monitor
package sim_halt_pkg;
  typedef enum logic [2:0] {
    RUNNING  = 3'd0,
    HALTED   = 3'd1,
    TIMEOUT  = 3'd2,
    DEADLOCK = 3'd3,
    ERROR    = 3'd4
  } status_e;
  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_e;
endpackage

// File: rtl/sim_halt_monitor_commit_popcount.sv
// commit_popcount: retire count and lowest halting channel of a commit group
module commit_popcount #(
  parameter int NUM_CH = 1,
  localparam int HW = $clog2(NUM_CH) + 1
) (
  input  logic [NUM_CH-1:0] commit,
  input  logic [NUM_CH-1:0] halt,
  output logic [HW-1:0]     count,
  output logic [HW-1:0]     halt_idx,
  output logic              halt_hit
);
  always_comb begin
    count = '0;
    halt_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      count = count + HW'(commit[i]);
      halt_idx = (commit[i] && halt[i]) ? HW'(i) : halt_idx;
    end
  end
  assign halt_hit = |(commit & halt);
endmodule

// File: rtl/sim_halt_monitor.sv
// sim_halt_monitor: end-of-simulation monitor for halt, error, timeout and deadlock
module sim_halt_monitor
  import sim_halt_pkg::*;
#(
  parameter int NUM_CH          = 1,
  parameter int CNT_W           = 32,
  parameter int TIMEOUT_CYCLES  = 100000000,
  parameter int DEADLOCK_CYCLES = 0,
  parameter int DRAIN_CYCLES    = 5,
  parameter int ERR_W           = 16,
  localparam int HW = $clog2(NUM_CH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] commit,
  input  logic [NUM_CH-1:0] halt,
  input  logic [ERR_W-1:0]  errcode,
  output logic              done,
  output logic [2:0]        status,
  output logic [HW-1:0]     halt_ch,
  output logic [ERR_W-1:0]  err_latched,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [63:0]       commit_count
);
  state_e state, state_n;
  status_e st, st_n;
  logic [HW-1:0] n_commit, hit_idx;
  logic hit, dl_hit, to_hit;
  logic [CNT_W-1:0] stall;
  logic [31:0] drain;
  logic [64:0] sum;
  commit_popcount #(.NUM_CH(NUM_CH)) u_pop (
    .commit   (commit),
    .halt     (halt),
    .count    (n_commit),
    .halt_idx (hit_idx),
    .halt_hit (hit)
  );
  assign dl_hit = (DEADLOCK_CYCLES != 0) && (commit == '0) && (stall == CNT_W'(DEADLOCK_CYCLES - 1));
  assign to_hit = cycle_count == CNT_W'(TIMEOUT_CYCLES - 1);
  assign sum = {1'b0, commit_count} + 65'(n_commit);
  assign done = state == DONE;
  assign status = st;
  always_comb begin
    st_n = st;
    state_n = state;
    if (state == RUN) begin
      st_n = (errcode != '0) ? ERROR : hit ? HALTED : dl_hit ? DEADLOCK : to_hit ? TIMEOUT : RUNNING;
      state_n = (st_n == RUNNING) ? RUN : (st_n == ERROR && DRAIN_CYCLES != 0) ? DRAIN : DONE;
    end else if (state == DRAIN) begin
      state_n = (drain == 32'd1) ? DONE : DRAIN;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      st <= RUNNING;
      halt_ch <= '0;
      err_latched <= '0;
      cycle_count <= '0;
      commit_count <= '0;
      stall <= '0;
      drain <= '0;
    end else begin
      state <= state_n;
      st <= st_n;
      if (state != DONE) commit_count <= sum[64] ? '1 : sum[63:0];
      if (state == RUN) begin
        cycle_count <= cycle_count + CNT_W'(1);
        stall <= (commit != '0) ? '0 : stall + CNT_W'(1);
        if (st_n == ERROR) begin
          err_latched <= errcode;
          drain <= 32'(DRAIN_CYCLES);
        end
        if (st_n == HALTED) halt_ch <= hit_idx;
      end
      if (state == DRAIN) drain <= drain - 32'd1;
    end
  end
endmodule

// File: tb/tb_sim_halt_monitor.sv
// tb_sim_halt_monitor: directed and randomized checks against a cause/timing model
module tb_sim_halt_monitor;
  localparam int NCH = 4, CW = 16, TO = 40, DL = 4, DR = 5, EW = 16;
  logic clk = 0, rst = 1;
  logic [NCH-1:0] commit = '0, halt = '0;
  logic [EW-1:0] errcode = '0;
  logic done;
  logic [2:0] status, halt_ch;
  logic [EW-1:0] err_latched;
  logic [CW-1:0] cycle_count;
  logic [63:0] commit_count;
  int checks = 0, errors = 0;
  int ms = 0, m_st = 0, m_hc = 0, m_left = 0, m_cyc = 0, m_idle = 0;
  logic [EW-1:0] m_el = '0;
  longint unsigned m_cc = 0;
  sim_halt_monitor #(
    .NUM_CH(NCH), .CNT_W(CW), .TIMEOUT_CYCLES(TO),
    .DEADLOCK_CYCLES(DL), .DRAIN_CYCLES(DR), .ERR_W(EW)
  ) dut (
    .clk(clk), .rst(rst), .commit(commit), .halt(halt), .errcode(errcode),
    .done(done), .status(status), .halt_ch(halt_ch), .err_latched(err_latched),
    .cycle_count(cycle_count), .commit_count(commit_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic add_commits(input logic [NCH-1:0] c);
    longint unsigned n = longint'($countones(c));
    m_cc = (m_cc > 64'hFFFF_FFFF_FFFF_FFFF - n) ? 64'hFFFF_FFFF_FFFF_FFFF : m_cc + n;
  endtask
  task automatic model(input logic r, input logic [NCH-1:0] c, input logic [NCH-1:0] h, input logic [EW-1:0] e);
    int cause;
    if (r) begin
      ms = 0; m_st = 0; m_hc = 0; m_el = '0; m_cyc = 0; m_cc = 0; m_idle = 0; m_left = 0;
    end else if (ms == 0) begin
      cause = (e != 0) ? 4 : ((c & h) != 0) ? 1 : (c == 0 && m_idle + 1 == DL) ? 3 : (m_cyc + 1 == TO) ? 2 : 0;
      add_commits(c);
      m_idle = (c != 0) ? 0 : m_idle + 1;
      m_cyc++;
      if (cause == 4) begin
        m_st = 4; m_el = e; m_left = DR; ms = (DR == 0) ? 2 : 1;
      end else if (cause != 0) begin
        m_st = cause; ms = 2;
        if (cause == 1) for (int i = NCH - 1; i >= 0; i--) if (c[i] && h[i]) m_hc = i;
      end
    end else if (ms == 1) begin
      add_commits(c);
      m_left--;
      if (m_left == 0) ms = 2;
    end
  endtask
  task automatic step(input logic r, input logic [NCH-1:0] c, input logic [NCH-1:0] h, input logic [EW-1:0] e);
    rst = r; commit = c; halt = h; errcode = e;
    @(posedge clk);
    model(r, c, h, e);
    #1;
    chk("done", 64'(done), 64'(ms == 2));
    chk("status", 64'(status), 64'(m_st));
    chk("halt_ch", 64'(halt_ch), 64'(m_hc));
    chk("err_latched", 64'(err_latched), 64'(m_el));
    chk("cycle_count", 64'(cycle_count), 64'(CW'(m_cyc)));
    chk("commit_count", commit_count, m_cc);
  endtask
  function automatic logic [NCH-1:0] nz();
    return NCH'($urandom_range(1, 15));
  endfunction
  initial begin
    step(1, '0, '0, '0);
    step(1, 4'hF, 4'hF, 16'h5);
    chk("reset_status", 64'(status), 64'd0);
    repeat (3) step(0, 4'b1111, '0, '0);
    step(0, 4'b0110, 4'b0100, '0);
    chk("halt_status", 64'(status), 64'd1);
    chk("halt_ch_2", 64'(halt_ch), 64'd2);
    chk("halt_cc_14", commit_count, 64'd14);
    step(0, 4'hF, 4'hF, 16'h3);
    chk("done_holds", 64'(commit_count), 64'd14);
    step(1, '0, '0, '0);
    repeat (19) step(0, nz(), '0, '0);
    step(0, nz(), '0, 16'd7);
    step(0, nz(), 4'hF, 16'd9);
    chk("drain_not_done", 64'(done), 64'd0);
    repeat (3) step(0, nz(), '0, '0);
    chk("drain_edge4", 64'(done), 64'd0);
    step(0, nz(), '0, '0);
    chk("drain_done25", 64'(done), 64'd1);
    chk("err_status", 64'(status), 64'd4);
    chk("err_first", 64'(err_latched), 64'd7);
    chk("err_cyc", 64'(cycle_count), 64'd20);
    step(1, '0, '0, '0);
    step(0, 4'b0001, 4'b0001, 16'd3);
    chk("err_beats_halt", 64'(status), 64'd4);
    chk("halt_ch_0", 64'(halt_ch), 64'd0);
    step(1, '0, '0, '0);
    repeat (6) step(0, nz(), '0, '0);
    repeat (3) step(0, '0, '0, '0);
    step(0, 4'b1000, '0, '0);
    repeat (3) step(0, '0, '0, '0);
    chk("dl_restart", 64'(done), 64'd0);
    step(0, '0, '0, '0);
    chk("dl_status", 64'(status), 64'd3);
    step(1, '0, '0, '0);
    repeat (5) step(0, nz(), '0, '0);
    step(0, nz(), '0, 16'hBEEF);
    step(0, nz(), '0, '0);
    step(1, nz(), 4'hF, 16'h1);
    chk("rst_in_drain", 64'(status), 64'd0);
    chk("rst_in_drain_cc", commit_count, 64'd0);
    repeat (TO) step(0, nz(), '0, '0);
    chk("to_status", 64'(status), 64'd2);
    chk("to_cyc", 64'(cycle_count), 64'(TO));
    step(1, '0, '0, '0);
    chk("rst_in_done", 64'(done), 64'd0);
    repeat (TO) step(0, nz(), '0, '0);
    chk("to_again", 64'(status), 64'd2);
    for (int r = 0; r < 12; r++) begin
      step(1, '0, '0, '0);
      for (int k = 0; k < 70 && ms != 2; k++)
        step(0, ($urandom_range(0, 4) == 0) ? '0 : nz(),
             ($urandom_range(0, 12) == 0) ? NCH'($urandom) : '0,
             ($urandom_range(0, 25) == 0) ? EW'($urandom_range(1, 65535)) : '0);
      repeat (3) step(0, NCH'($urandom), NCH'($urandom), EW'($urandom));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
